// File: rtl/hamming_mem_pkg.sv
// Shared types and constants for the Hamming-protected SRAM front end
// (host/scrub arbiter, read pipeline, host interface).
package hamming_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RD   = 4'b0010,
    WAIT = 4'b0100,
    WB   = 4'b1000
  } scrub_state_t;

  typedef struct packed {
    logic              enable;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_if.sv
// Host command/response bus of the scrub controller; the host drives the
// master side, the controller implements the slave side.
interface hamming_scrub_ctrl_if;
  import hamming_mem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/hamming_rd_pipe.sv
// Tags accepted host reads and raises rvalid exactly when the SRAM returns
// their data; independent of the scrub FSM so in-flight reads always complete.
module hamming_rd_pipe
  import hamming_mem_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_accept_i,
  input  logic [DATA_W-1:0] mem_data_out_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [MEM_RD_LAT:0] tag_q;
  logic [MEM_RD_LAT:0] tag_d;

  // Next tag vector: shift in this cycle's acceptance.
  always_comb begin
    tag_d = {tag_q[MEM_RD_LAT-1:0], rd_accept_i};
  end

  // Tag shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign rvalid_o = tag_q[MEM_RD_LAT];
  assign rdata_o  = tag_q[MEM_RD_LAT] ? mem_data_out_i : {DATA_W{1'b0}};

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Host/scrub arbiter in front of the Hamming-protected SRAM: host commands pass
// through, and periodic read/write-back pairs walk every address to flush single-bit errors.
module hamming_scrub_ctrl
  import hamming_mem_pkg::*;
#(
  parameter int MEM_RD_LAT     = 1,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scrub_en_i,
  hamming_scrub_ctrl_if.slave host_if,
  output logic                mem_enable_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_in_o,
  input  logic [DATA_W-1:0]   mem_data_out_i,
  output logic                scrub_busy_o,
  output logic                pass_done_o,
  output logic [15:0]         pass_count_o
);

  localparam int IV_W = $clog2(SCRUB_INTERVAL);
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);
  localparam int WT_W = $clog2(MEM_RD_LAT + 1);

  scrub_state_t      state_q, state_d;
  logic [IV_W-1:0]   ivl_q, ivl_d;
  logic              pend_q, pend_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic [WT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              pdone_q, pdone_d;
  logic [15:0]       pcnt_q, pcnt_d;

  logic ivl_hit_s;
  logic scrub_go_s;
  logic host_acc_s;
  logic host_ready_s;

  // Arbitration: a pending scrub wins when the host is quiet or has starved it long enough.
  always_comb begin
    scrub_go_s   = (state_q == IDLE) && pend_q &&
                   (!host_if.req || (starve_q == ST_W'(STARVE_LIMIT)));
    host_ready_s = (state_q == IDLE) && !scrub_go_s;
    host_acc_s   = host_ready_s && host_if.req;
  end

  // Interval counter, pending flag and starvation counter.
  always_comb begin
    ivl_hit_s = 1'b0;
    ivl_d     = ivl_q;
    pend_d    = pend_q;
    starve_d  = starve_q;
    if (!scrub_en_i) begin
      ivl_d = '0;
    end else if (ivl_q == IV_W'(SCRUB_INTERVAL - 1)) begin
      ivl_d     = '0;
      ivl_hit_s = 1'b1;
    end else begin
      ivl_d = ivl_q + IV_W'(1);
    end
    // A request landing on the write-back cycle survives the clear.
    if (!scrub_en_i) begin
      pend_d = 1'b0;
    end else if (ivl_hit_s) begin
      pend_d = 1'b1;
    end else if (state_q == WB) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (scrub_go_s || !pend_q) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && host_if.req && (starve_q != ST_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + ST_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Scrub FSM and next mem_* command.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    saddr_d = saddr_q;
    pcnt_d  = pcnt_q;
    pdone_d = 1'b0;
    cmd_d   = '0;
    case (state_q)
      IDLE: begin
        if (scrub_go_s) begin
          state_d      = RD;
          cmd_d.enable = 1'b1;
          cmd_d.addr   = saddr_q;
        end else if (host_acc_s) begin
          cmd_d.enable = 1'b1;
          cmd_d.we     = host_if.we;
          cmd_d.addr   = host_if.addr;
          cmd_d.data   = host_if.we ? host_if.wdata : {DATA_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        // The write-data register doubles as the scrub buffer.
        if (wait_q == WT_W'(MEM_RD_LAT - 1)) begin
          state_d      = WB;
          cmd_d.enable = 1'b1;
          cmd_d.we     = 1'b1;
          cmd_d.addr   = saddr_q;
          cmd_d.data   = mem_data_out_i;
        end else begin
          wait_d = wait_q + WT_W'(1);
        end
      end
      WB: begin
        state_d = IDLE;
        saddr_d = saddr_q + ADDR_W'(1);
        if (saddr_q == {ADDR_W{1'b1}}) begin
          pdone_d = 1'b1;
          pcnt_d  = sat_inc16(pcnt_q);
        end else begin
          pdone_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ivl_q    <= '0;
      pend_q   <= 1'b0;
      starve_q <= '0;
      wait_q   <= '0;
      saddr_q  <= '0;
      cmd_q    <= '0;
      pdone_q  <= 1'b0;
      pcnt_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ivl_q    <= ivl_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      saddr_q  <= saddr_d;
      cmd_q    <= cmd_d;
      pdone_q  <= pdone_d;
      pcnt_q   <= pcnt_d;
    end
  end

  hamming_rd_pipe #(
    .MEM_RD_LAT (MEM_RD_LAT)
  ) u_rd_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_accept_i    (host_acc_s && !host_if.we),
    .mem_data_out_i (mem_data_out_i),
    .rvalid_o       (host_if.rvalid),
    .rdata_o        (host_if.rdata)
  );

  assign host_if.ready = host_ready_s;
  assign mem_enable_o  = cmd_q.enable;
  assign mem_we_o      = cmd_q.we;
  assign mem_addr_o    = cmd_q.addr;
  assign mem_data_in_o = cmd_q.data;
  assign scrub_busy_o  = (state_q != IDLE);
  assign pass_done_o   = pdone_q;
  assign pass_count_o  = pcnt_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with a Hamming(12,8) SRAM model behind it.
module tb_hamming_scrub_ctrl;

  localparam int IVL = 8;
  localparam int LIM = 4;

  logic        clk;
  logic        rst_n;
  logic        scrub_en;
  logic        mem_enable, mem_we, scrub_busy, pass_done;
  logic [7:0]  mem_addr, mem_data_in, mem_rdata;
  logic [15:0] pass_count;
  logic        flip_req;
  logic [7:0]  flip_addr;
  logic [11:0] flip_mask;
  logic [11:0] cw_mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int waited;
  int got;
  int en_seen;
  int last_wr;
  logic [16:0] cmd;
  logic [16:0] seen [2];
  logic        e_rdy, e_busy, e_rv;
  logic        rdy_hist [32];

  logic       h_we   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] h_addr [6] = '{8'd10, 8'd20, 8'd255, 8'd10, 8'd20, 8'd255};
  logic [7:0] h_data [6] = '{8'h2C, 8'h3C, 8'hFF, 8'h2C, 8'h3C, 8'hFF};

  hamming_scrub_ctrl_if hif ();

  hamming_scrub_ctrl #(
    .MEM_RD_LAT     (1),
    .SCRUB_INTERVAL (IVL),
    .STARVE_LIMIT   (LIM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scrub_en_i     (scrub_en),
    .host_if        (hif),
    .mem_enable_o   (mem_enable),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_data_in_o  (mem_data_in),
    .mem_data_out_i (mem_rdata),
    .scrub_busy_o   (scrub_busy),
    .pass_done_o    (pass_done),
    .pass_count_o   (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ham_syn(input logic [11:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int p = 1; p <= 12; p++) if (c[p-1]) s = s ^ 4'(p);
    return s;
  endfunction

  function automatic logic [11:0] ham_enc(input logic [7:0] d);
    logic [11:0] c;
    logic [3:0]  s;
    int j;
    c = 12'd0;
    j = 0;
    for (int p = 1; p <= 12; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        c[p-1] = d[j];
        j++;
      end
    end
    s = ham_syn(c);
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2]; c[7] = s[3];
    return c;
  endfunction

  function automatic logic [7:0] ham_dec(input logic [11:0] c_in);
    logic [11:0] c;
    logic [7:0]  d;
    int s, j;
    c = c_in;
    s = int'(ham_syn(c));
    if (s != 0 && s <= 12) c[s-1] = ~c[s-1];
    j = 0;
    d = 8'd0;
    for (int p = 1; p <= 12; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // SRAM model: stores codewords, returns corrected data one cycle after a read.
  always @(posedge clk) begin
    if (flip_req) cw_mem[flip_addr] <= cw_mem[flip_addr] ^ flip_mask;
    if (mem_enable) begin
      if (mem_we) cw_mem[mem_addr] <= ham_enc(mem_data_in);
      else        mem_rdata <= ham_dec(cw_mem[mem_addr]);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cmd(input int budget, output int w, output logic [16:0] c);
    w = -1;
    c = 17'd0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (mem_enable) begin
        w = i;
        c = {mem_we, mem_addr, mem_data_in};
        break;
      end
    end
  endtask

  task automatic dut_reset(input logic en_after);
    rst_n = 1'b0;
    step();
    step();
    rst_n    = 1'b1;
    scrub_en = en_after;
  endtask

  initial begin
    rst_n = 1'b0; scrub_en = 1'b1;
    hif.req = 1'b0; hif.we = 1'b0; hif.addr = 8'd0; hif.wdata = 8'd0;
    flip_req = 1'b0; flip_addr = 8'd0; flip_mask = 12'd0;
    mem_rdata = 8'd0;

    // Reset state, then quiet period and first scrub pair.
    repeat (3) step();
    check_val("rst_mem", {mem_enable, mem_we, mem_addr, mem_data_in}, 18'd0);
    check_val("rst_ready", hif.ready, 1'b1);
    check_val("rst_busy", scrub_busy, 1'b0);
    check_val("rst_pass_count", pass_count, 16'd0);
    check_val("rst_rvalid_done", {hif.rvalid, pass_done}, 2'b00);
    rst_n = 1'b1;
    en_seen = 0;
    for (int i = 1; i < IVL; i++) begin
      step();
      if (mem_enable) en_seen++;
    end
    check_val("idle_no_enable", en_seen, 0);
    wait_cmd(40, waited, cmd);
    check_val("first_scrub_lat", waited, 2);
    check_val("first_scrub_rd", cmd, {1'b0, 8'd0, 8'd0});
    check_val("first_scrub_busy", scrub_busy, 1'b1);
    wait_cmd(5, waited, cmd);
    check_val("first_scrub_wb", cmd, {1'b1, 8'd0, 8'd0});
    scrub_en = 1'b0;
    step(); step();

    // Host passthrough: three writes then three reads, back to back.
    for (int k = 0; k < 8; k++) begin
      step();
      if (k >= 1 && k <= 6)
        check_val($sformatf("host_cmd%0d", k-1), {mem_enable, mem_we, mem_addr, mem_data_in},
                  {1'b1, h_we[k-1], h_addr[k-1], (h_we[k-1] ? h_data[k-1] : 8'd0)});
      if (k >= 2) begin
        e_rv = (k - 2 >= 3);
        check_val($sformatf("host_rvalid%0d", k), hif.rvalid, e_rv);
        if (e_rv) check_val($sformatf("host_rdata%0d", k), hif.rdata, h_data[k-2]);
      end
      if (k < 6) begin
        check_val("host_ready", hif.ready, 1'b1);
        hif.req = 1'b1; hif.we = h_we[k]; hif.addr = h_addr[k]; hif.wdata = h_data[k];
      end else begin
        hif.req = 1'b0;
      end
    end
    check_val("host_idle_enable", mem_enable, 1'b0);

    // Scrub correction: corrupt one codeword bit of address 30, let the scrubber repair it.
    hif.req = 1'b1; hif.we = 1'b1; hif.addr = 8'd30; hif.wdata = 8'hA8;
    step();
    hif.req = 1'b0;
    step(); step();
    flip_req = 1'b1; flip_addr = 8'd30; flip_mask = 12'h020;
    step();
    flip_req = 1'b0;
    dut_reset(1'b1);
    got = 0;
    for (int i = 0; i < 400 && got < 2; i++) begin
      step();
      if (mem_enable && mem_addr == 8'd30) begin
        seen[got] = {mem_we, mem_addr, mem_data_in};
        got++;
      end
    end
    check_val("scrub30_count", got, 2);
    check_val("scrub30_rd", seen[0], {1'b0, 8'd30, 8'h00});
    check_val("scrub30_wb", seen[1], {1'b1, 8'd30, 8'hA8});
    scrub_en = 1'b0;
    step(); step();
    check_val("scrub30_clean", cw_mem[30], ham_enc(8'hA8));

    // Starvation: continuous host reads of address 20 while a scrub is pending.
    dut_reset(1'b0);
    step();
    scrub_en = 1'b1; hif.req = 1'b1; hif.we = 1'b0; hif.addr = 8'd20;
    rdy_hist[0] = 1'b1;
    for (int k = 1; k <= IVL + LIM + 4; k++) begin
      step();
      e_rdy  = !(k >= IVL + LIM && k <= IVL + LIM + 3);
      e_busy = (k >= IVL + LIM + 1 && k <= IVL + LIM + 3);
      e_rv   = (k >= 2) ? rdy_hist[k-2] : 1'b0;
      rdy_hist[k] = e_rdy;
      check_val($sformatf("starve_ready%0d", k), hif.ready, e_rdy);
      check_val($sformatf("starve_busy%0d", k), scrub_busy, e_busy);
      check_val($sformatf("starve_rvalid%0d", k), hif.rvalid, e_rv);
      if (e_rv) check_val($sformatf("starve_rdata%0d", k), hif.rdata, 8'h3C);
    end
    hif.req = 1'b0; scrub_en = 1'b0;
    step(); step();

    // Full pass over all 256 addresses with no host traffic.
    dut_reset(1'b1);
    got = 0;
    last_wr = -1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (pass_done) begin
        got = 1;
        break;
      end
      if (mem_enable && mem_we) last_wr = int'(mem_addr);
    end
    check_val("pass_done_seen", got, 1);
    check_val("pass_last_wb", last_wr, 255);
    check_val("pass_count_1", pass_count, 16'd1);
    step();
    check_val("pass_done_pulse", pass_done, 1'b0);
    wait_cmd(20, waited, cmd);
    check_val("pass_wrap_rd", cmd, {1'b0, 8'd0, 8'd0});

    // Reset in the middle of a pair.
    wait_cmd(5, waited, cmd);
    check_val("pair0_wb", cmd, {1'b1, 8'd0, 8'd0});
    wait_cmd(20, waited, cmd);
    check_val("pair1_rd", cmd, {1'b0, 8'd1, 8'd0});
    step();
    check_val("pair1_wait_busy", {scrub_busy, mem_enable}, 2'b10);
    rst_n = 1'b0;
    #1;
    check_val("midrst_enable", mem_enable, 1'b0);
    check_val("midrst_busy_ready", {scrub_busy, hif.ready}, 2'b01);
    check_val("midrst_pass_count", pass_count, 16'd0);
    step(); step();
    rst_n = 1'b1;
    wait_cmd(30, waited, cmd);
    check_val("midrst_next_lat", waited, IVL + 1);
    check_val("midrst_next_rd", cmd, {1'b0, 8'd0, 8'd0});
    scrub_en = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
